// File: rtl/seq_comparator.sv
// Bit-serial magnitude comparator: walks the operands MSB first, one bit per clock,
// and stops at the first differing bit. Optional two's-complement mode.
module seq_comparator #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1,
    localparam int NB       = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             e,
    output logic             g,
    output logic [NB-1:0]    nbits
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic {IDLE, CMP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
    logic             smode_q, smode_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [NB-1:0]    cnt_q, cnt_d;
    logic [NB-1:0]    nbits_q, nbits_d;
    logic             l_q, l_d, e_q, e_d, g_q, g_d;
    logic             done_q, done_d;

    logic msb_a, msb_b, at_sign_bit;
    assign msb_a       = sa_q[WIDTH-1];
    assign msb_b       = sb_q[WIDTH-1];
    assign at_sign_bit = (idx_q == IW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        smode_d = smode_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        nbits_d = nbits_q;
        l_d     = l_q;
        e_d     = e_q;
        g_d     = g_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = b;
                    smode_d = signed_mode & SIGNED_EN;
                    idx_d   = IW'(WIDTH - 1);
                    cnt_d   = '0;
                    state_d = CMP;
                end
            end
            CMP: begin
                cnt_d = cnt_q + 1'b1;
                if (msb_a != msb_b) begin
                    // A set sign bit means the smaller value, so the sense flips there.
                    if (smode_q && at_sign_bit) begin
                        l_d = msb_a;
                        g_d = msb_b;
                    end else begin
                        l_d = msb_b;
                        g_d = msb_a;
                    end
                    e_d     = 1'b0;
                    nbits_d = cnt_q + 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    sa_d  = sa_q << 1;
                    sb_d  = sb_q << 1;
                    idx_d = idx_q - 1'b1;
                end else begin
                    l_d     = 1'b0;
                    e_d     = 1'b1;
                    g_d     = 1'b0;
                    nbits_d = cnt_q + 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            smode_q <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            nbits_q <= '0;
            l_q     <= 1'b0;
            e_q     <= 1'b0;
            g_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            smode_q <= smode_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            nbits_q <= nbits_d;
            l_q     <= l_d;
            e_q     <= e_d;
            g_q     <= g_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == CMP);
    assign done  = done_q;
    assign l     = l_q;
    assign e     = e_q;
    assign g     = g_q;
    assign nbits = nbits_q;
endmodule

// File: tb/tb_seq_comparator.sv
// Bench for seq_comparator: directed scenarios plus random compares, scored
// against an arithmetic reference model through an expected-result queue.
module tb_seq_comparator;
    localparam int WIDTH = 8;
    localparam int NB    = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             rst, start, signed_mode;
    logic [WIDTH-1:0] a, b;
    logic             busy, done, l, e, g;
    logic [NB-1:0]    nbits;

    logic             start2, sm2;
    logic [WIDTH-1:0] a2, b2;
    logic             busy2, done2, l2, e2, g2;
    logic [NB-1:0]    nbits2;

    seq_comparator #(.WIDTH(WIDTH), .SIGNED_EN(1'b1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .l(l), .e(e), .g(g), .nbits(nbits)
    );

    seq_comparator #(.WIDTH(WIDTH), .SIGNED_EN(1'b0)) u_dut_uns (
        .clk(clk), .rst(rst), .start(start2), .signed_mode(sm2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .l(l2), .e(e2), .g(g2), .nbits(nbits2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int tests = 0;
    int fails = 0;
    logic [NB+2:0] exp_q[$];
    int            cyc_q[$];

    // Position-of-highest-difference model: n = WIDTH - p, or WIDTH when equal.
    function automatic int calc_n(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        logic [WIDTH-1:0] d;
        d = x ^ y;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (d[i]) return WIDTH - i;
        return WIDTH;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Call between clock edges; start is accepted at the next edge.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib,
                         input logic ism, output int n_out);
        logic lx, ex, gx;
        int   n;
        n = calc_n(ia, ib);
        if (ism) begin
            lx = $signed(ia) < $signed(ib);
            gx = $signed(ia) > $signed(ib);
        end else begin
            lx = ia < ib;
            gx = ia > ib;
        end
        ex = (ia == ib);
        exp_q.push_back({lx, ex, gx, NB'(n)});
        cyc_q.push_back(cyc + 1 + n);
        start       = 1'b1;
        a           = ia;
        b           = ib;
        signed_mode = ism;
        @(posedge clk);
        #1;
        start       = 1'b0;
        a           = WIDTH'($urandom);
        b           = WIDTH'($urandom);
        signed_mode = 1'($urandom);
        n_out       = n;
    endtask

    // Returns at the falling edge of the done cycle; counts busy cycles seen first.
    task automatic wait_done(input int exp_busy);
        int bcnt;
        bit got;
        bcnt = 0;
        got  = 1'b0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) bcnt++;
        end
        chk("done_timeout", int'(got), 1);
        chk("busy_cycles", bcnt, exp_busy);
    endtask

    always @(negedge clk) begin
        if (done) begin
            tests++;
            if (busy) begin
                fails++;
                $display("FAIL done_busy_overlap: busy=%0b done=%0b", busy, done);
            end
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done with no compare pending (t=%0t)", $time);
            end else begin
                logic [NB+2:0] ex;
                int            ec;
                ex = exp_q.pop_front();
                ec = cyc_q.pop_front();
                tests++;
                if ({l, e, g, nbits} !== ex) begin
                    fails++;
                    $display("FAIL result: got l=%0b e=%0b g=%0b nbits=%0d expected l=%0b e=%0b g=%0b nbits=%0d",
                             l, e, g, nbits, ex[NB+2], ex[NB+1], ex[NB], ex[NB-1:0]);
                end
                tests++;
                if (cyc != ec) begin
                    fails++;
                    $display("FAIL latency: done at cycle %0d expected %0d", cyc, ec);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit got2;
        rst = 1'b1; start = 1'b1; signed_mode = 1'b0; a = 8'hFF; b = 8'h00;
        start2 = 1'b0; sm2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_leg", {l, e, g}, 0);
        chk("rst_nbits", nbits, 0);
        @(negedge clk);
        chk("rst_no_start_busy", busy, 0);
        chk("rst_no_start_done", done, 0);

        issue(8'hFF, 8'hFC, 1'b0, n); wait_done(n);
        chk("late_diff_n", n, 7);
        chk("late_diff_g", g, 1);
        issue(8'h5A, 8'h5A, 1'b0, n); wait_done(n);
        chk("equal_e", e, 1);
        issue(8'h80, 8'h01, 1'b1, n); wait_done(n);
        chk("sign_inv_l", l, 1);
        issue(8'h80, 8'h01, 1'b0, n); wait_done(n);
        chk("sign_uns_g", g, 1);

        a2 = 8'h80; b2 = 8'h01; sm2 = 1'b1; start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        got2 = 1'b0;
        for (int k = 0; k < WIDTH + 4; k++) begin
            @(negedge clk);
            if (done2) begin
                got2 = 1'b1;
                break;
            end
        end
        chk("nosigned_done", int'(got2), 1);
        chk("nosigned_leg", {l2, e2, g2}, 3'b001);
        chk("nosigned_nbits", nbits2, 1);

        @(negedge clk);
        issue(8'h00, 8'h0F, 1'b0, n);
        chk("busy_start_n", n, 5);
        @(posedge clk);
        #1;
        start = 1'b1; a = 8'hFF; b = 8'h00; signed_mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n - 2);
        chk("busy_start_l", l, 1);
        issue(8'h10, 8'h10, 1'b0, n); wait_done(n);
        chk("b2b_e", e, 1);

        start = 1'b1; a = 8'h01; b = 8'h00; signed_mode = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_leg", {l, e, g}, 0);
        chk("abort_nbits", nbits, 0);
        repeat (WIDTH + 2) @(negedge clk);
        issue(8'h01, 8'h00, 1'b0, n); wait_done(n);
        chk("after_abort_g", g, 1);
        chk("after_abort_nbits", nbits, 8);

        for (int i = 0; i < 150; i++) begin
            logic [WIDTH-1:0] ra, rb;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ra = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0: rb = ra;
                1: rb = ra ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
                default: rb = WIDTH'($urandom);
            endcase
            issue(ra, rb, 1'($urandom), n);
            wait_done(n);
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
